// File: rtl/pe_ws_sat.sv
// pe_ws_sat: weight-stationary systolic PE with rounded saturating MAC, psum bypass and fused ReLU
module pe_ws_sat #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pe_enabled,
  input  logic                  pe_clear,
  input  logic [1:0]            pe_mode,
  input  logic [DATA_WIDTH-1:0] pe_psum_in,
  input  logic [DATA_WIDTH-1:0] pe_weight_in,
  input  logic                  pe_accept_w_in,
  input  logic [DATA_WIDTH-1:0] pe_input_in,
  input  logic                  pe_valid_in,
  input  logic                  pe_switch_in,
  output logic [DATA_WIDTH-1:0] pe_psum_out,
  output logic [DATA_WIDTH-1:0] pe_weight_out,
  output logic                  pe_accept_w_out,
  output logic [DATA_WIDTH-1:0] pe_input_out,
  output logic                  pe_valid_out,
  output logic                  pe_switch_out,
  output logic                  pe_ovf_sticky
);
  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [PW:0] HALF = (PW+1)'(1) << (FRAC_BITS - 1);
  localparam logic signed [PW:0] SMAX = {{(PW-W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW:0] SMIN = {{(PW-W+2){1'b1}}, {(W-1){1'b0}}};
  logic [W-1:0] active_q, shadow_q, psum_q, psum_d, weight_q, input_q, sat_v;
  logic accept_q, valid_q, switch_q, ovf_q, ovf_d, sat_hi, sat_lo;
  logic signed [PW-1:0] mul;
  logic signed [PW:0] rnd_pre, rnd, sum;
  always_comb begin
    mul = {{W{pe_input_in[W-1]}}, pe_input_in} * {{W{active_q[W-1]}}, active_q};
    rnd_pre = {mul[PW-1], mul} + HALF;
    rnd = rnd_pre >>> FRAC_BITS;
    sum = rnd + {{(PW+1-W){pe_psum_in[W-1]}}, pe_psum_in};
    sat_hi = sum > SMAX;
    sat_lo = sum < SMIN;
    sat_v = sat_hi ? SMAX[W-1:0] : sat_lo ? SMIN[W-1:0] : sum[W-1:0];
    psum_d = (!pe_valid_in || pe_mode == 2'b01) ? pe_psum_in
           : (pe_mode == 2'b10 && sat_v[W-1]) ? '0 : sat_v;
    ovf_d = ovf_q | (pe_valid_in && pe_mode != 2'b01 && (sat_hi || sat_lo));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= '0;
      shadow_q <= '0;
      psum_q   <= '0;
      weight_q <= '0;
      input_q  <= '0;
      accept_q <= 1'b0;
      valid_q  <= 1'b0;
      switch_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (pe_enabled) begin
      if (pe_clear) begin
        psum_q   <= '0;
        weight_q <= '0;
        input_q  <= '0;
        accept_q <= 1'b0;
        valid_q  <= 1'b0;
        switch_q <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        psum_q   <= psum_d;
        ovf_q    <= ovf_d;
        valid_q  <= pe_valid_in;
        switch_q <= pe_switch_in;
        input_q  <= pe_valid_in ? pe_input_in : input_q;
        weight_q <= pe_accept_w_in ? pe_weight_in : '0;
        accept_q <= pe_accept_w_in;
        shadow_q <= pe_accept_w_in ? pe_weight_in : shadow_q;
        active_q <= pe_switch_in ? shadow_q : active_q;
      end
    end
  end
  assign pe_psum_out     = psum_q;
  assign pe_weight_out   = weight_q;
  assign pe_accept_w_out = accept_q;
  assign pe_input_out    = input_q;
  assign pe_valid_out    = valid_q;
  assign pe_switch_out   = switch_q;
  assign pe_ovf_sticky   = ovf_q;
endmodule

// File: tb/tb_pe_ws_sat.sv
// tb_pe_ws_sat: scoreboard bench for pe_ws_sat; a behavioural model queues the expected outputs for each driven cycle
module tb_pe_ws_sat;
  localparam int W = 16;
  localparam int F = 8;
  typedef struct packed {
    logic [W-1:0] psum, weight;
    logic acc;
    logic [W-1:0] inp;
    logic val, sw, ovf;
  } out_t;
  typedef struct {
    logic en, clr;
    logic [1:0] md;
    logic vld;
    logic [W-1:0] inp, ps;
    logic acc;
    logic [W-1:0] w;
    logic sw;
  } stim_t;
  logic clk = 1'b0, rst = 1'b0;
  logic pe_enabled, pe_clear, pe_accept_w_in, pe_valid_in, pe_switch_in;
  logic [1:0] pe_mode;
  logic [W-1:0] pe_psum_in, pe_weight_in, pe_input_in;
  logic [W-1:0] pe_psum_out, pe_weight_out, pe_input_out;
  logic pe_accept_w_out, pe_valid_out, pe_switch_out, pe_ovf_sticky;
  out_t got, m, e;
  logic [W-1:0] m_act, m_shd;
  out_t sb[$];
  int checks = 0, passes = 0;
  pe_ws_sat #(.DATA_WIDTH(W), .FRAC_BITS(F)) dut (
    .clk(clk), .rst(rst), .pe_enabled(pe_enabled), .pe_clear(pe_clear), .pe_mode(pe_mode),
    .pe_psum_in(pe_psum_in), .pe_weight_in(pe_weight_in), .pe_accept_w_in(pe_accept_w_in),
    .pe_input_in(pe_input_in), .pe_valid_in(pe_valid_in), .pe_switch_in(pe_switch_in),
    .pe_psum_out(pe_psum_out), .pe_weight_out(pe_weight_out), .pe_accept_w_out(pe_accept_w_out),
    .pe_input_out(pe_input_out), .pe_valid_out(pe_valid_out), .pe_switch_out(pe_switch_out),
    .pe_ovf_sticky(pe_ovf_sticky)
  );
  assign got = {pe_psum_out, pe_weight_out, pe_accept_w_out, pe_input_out, pe_valid_out, pe_switch_out, pe_ovf_sticky};
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  function automatic stim_t st(logic en, logic clr, logic [1:0] md, logic vld, logic [W-1:0] inp,
                               logic [W-1:0] ps, logic acc, logic [W-1:0] w, logic sw);
    stim_t s;
    s.en = en; s.clr = clr; s.md = md; s.vld = vld; s.inp = inp;
    s.ps = ps; s.acc = acc; s.w = w; s.sw = sw;
    return s;
  endfunction
  function automatic stim_t ld(logic [W-1:0] w);
    return st(1, 0, 2'd0, 0, '0, '0, 1, w, 0);
  endfunction
  function automatic stim_t swp();
    return st(1, 0, 2'd0, 0, '0, '0, 0, '0, 1);
  endfunction
  function automatic stim_t mac(logic [1:0] md, logic [W-1:0] inp, logic [W-1:0] ps);
    return st(1, 0, md, 1, inp, ps, 0, '0, 0);
  endfunction
  task automatic model_reset();
    m = '0;
    m_act = '0;
    m_shd = '0;
    sb.delete();
  endtask
  task automatic drive(input stim_t s);
    longint p, r, sum, lim;
    logic hit;
    logic [W-1:0] sv;
    pe_enabled = s.en; pe_clear = s.clr; pe_mode = s.md; pe_valid_in = s.vld;
    pe_input_in = s.inp; pe_psum_in = s.ps; pe_accept_w_in = s.acc;
    pe_weight_in = s.w; pe_switch_in = s.sw;
    if (s.en && s.clr) m = '0;
    else if (s.en) begin
      lim = longint'(1) << (W - 1);
      p = longint'($signed(s.inp)) * longint'($signed(m_act));
      r = (p + (longint'(1) << (F - 1))) >>> F;
      sum = r + longint'($signed(s.ps));
      hit = (sum > lim - 1) || (sum < -lim);
      sv = (sum > lim - 1) ? W'(lim - 1) : (sum < -lim) ? W'(-lim) : W'(sum);
      m.psum = (!s.vld || s.md == 2'd1) ? s.ps : (s.md == 2'd2 && $signed(sv) < 0) ? '0 : sv;
      if (s.vld && s.md != 2'd1 && hit) m.ovf = 1'b1;
      if (s.vld) m.inp = s.inp;
      m.val = s.vld;
      m.sw = s.sw;
      m.weight = s.acc ? s.w : '0;
      m.acc = s.acc;
      if (s.sw) m_act = m_shd;
      if (s.acc) m_shd = s.w;
    end
    sb.push_back(m);
  endtask
  task automatic test_reset();
    rst = 1'b0;
    drive(st(0, 0, 2'd0, 0, '0, '0, 0, '0, 0));
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (got !== '0) $display("FAIL reset got %h exp 0", got);
    else passes++;
    rst = 1'b1;
  endtask
  task automatic test_basic();
    stim_t q[$];
    q.push_back(ld(16'h0200));
    q.push_back(swp());
    q.push_back(mac(2'd0, 16'h0180, 16'h0100));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (got !== e) $display("FAIL basic[%0d] got %h exp %h", i, got, e);
      else passes++;
    end
    checks++;
    if (pe_psum_out !== 16'h0400 || pe_input_out !== 16'h0180 || pe_valid_out !== 1'b1)
      $display("FAIL basic_const psum %h exp 0400 inp %h exp 0180", pe_psum_out, pe_input_out);
    else passes++;
  endtask
  task automatic test_saturation();
    stim_t q[$];
    q.push_back(ld(16'h7F00));
    q.push_back(swp());
    q.push_back(mac(2'd0, 16'h0200, 16'h0000));
    for (int k = 0; k < 5; k++) q.push_back(mac(2'd0, W'(k + 1), W'(k * 3)));
    q.push_back(st(1, 1, 2'd0, 1, 16'h0200, '0, 1, 16'h1111, 1));
    q.push_back(mac(2'd3, 16'hFE00, 16'h0000));
    q.push_back(mac(2'd0, 16'h0200, 16'h8000));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (got !== e) $display("FAIL sat[%0d] got %h exp %h", i, got, e);
      else passes++;
      if (i == 2 || i == 8) begin
        checks++;
        if (pe_psum_out !== (i == 2 ? 16'h7FFF : 16'h0000) || pe_ovf_sticky !== (i == 2))
          $display("FAIL sat_const[%0d] psum %h ovf %b", i, pe_psum_out, pe_ovf_sticky);
        else passes++;
      end
    end
  endtask
  task automatic test_rounding();
    stim_t q[$];
    q.push_back(st(1, 1, 2'd0, 0, '0, '0, 0, '0, 0));
    q.push_back(ld(16'h0001));
    q.push_back(swp());
    q.push_back(mac(2'd0, 16'h0080, 16'h0000));
    q.push_back(mac(2'd0, 16'h007F, 16'h0000));
    q.push_back(mac(2'd0, 16'hFF80, 16'h0000));
    q.push_back(mac(2'd0, 16'hFF7F, 16'h0000));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (got !== e) $display("FAIL round[%0d] got %h exp %h", i, got, e);
      else passes++;
      if (i == 3) begin
        checks++;
        if (pe_psum_out !== 16'h0001) $display("FAIL round_const got %h exp 0001", pe_psum_out);
        else passes++;
      end
    end
  endtask
  task automatic test_relu();
    stim_t q[$];
    q.push_back(ld(16'h0100));
    q.push_back(swp());
    q.push_back(mac(2'd2, 16'hFF00, 16'h0000));
    q.push_back(mac(2'd0, 16'hFF00, 16'h0000));
    q.push_back(mac(2'd2, 16'h0300, 16'h7F00));
    q.push_back(mac(2'd2, 16'h8000, 16'h8000));
    q.push_back(mac(2'd3, 16'hFF00, 16'h0010));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (got !== e) $display("FAIL relu[%0d] got %h exp %h", i, got, e);
      else passes++;
      if (i == 2 || i == 3) begin
        checks++;
        if (pe_psum_out !== (i == 2 ? 16'h0000 : 16'hFF00))
          $display("FAIL relu_const[%0d] got %h", i, pe_psum_out);
        else passes++;
      end
    end
  endtask
  task automatic test_stall_bypass();
    stim_t q[$];
    q.push_back(st(1, 1, 2'd0, 0, '0, '0, 0, '0, 0));
    q.push_back(mac(2'd0, 16'h0200, 16'h0010));
    q.push_back(st(1, 0, 2'd0, 1, 16'h0300, 16'h0020, 1, 16'h0A0A, 1));
    for (int k = 0; k < 3; k++)
      q.push_back(st(0, k == 1, 2'($urandom), 1'($urandom), W'($urandom), W'($urandom), 1'($urandom), W'($urandom), 1'($urandom)));
    q.push_back(mac(2'd0, 16'h0100, 16'h0001));
    q.push_back(mac(2'd1, 16'h7FFF, 16'h1234));
    q.push_back(mac(2'd1, 16'h4000, 16'hABCD));
    q.push_back(st(1, 0, 2'd0, 0, 16'h5555, 16'h0777, 0, '0, 0));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (got !== e) $display("FAIL stall[%0d] got %h exp %h", i, got, e);
      else passes++;
    end
    checks++;
    if (pe_psum_out !== 16'h0777 || pe_input_out !== 16'h4000)
      $display("FAIL bypass_const psum %h exp 0777 inp %h exp 4000", pe_psum_out, pe_input_out);
    else passes++;
  endtask
  task automatic test_weight_corner();
    stim_t q[$];
    q.push_back(ld(16'h0100));
    q.push_back(swp());
    q.push_back(ld(16'h0300));
    q.push_back(st(1, 0, 2'd0, 1, 16'h0100, 16'h0000, 1, 16'h0500, 1));
    q.push_back(mac(2'd0, 16'h0100, 16'h0000));
    q.push_back(swp());
    q.push_back(mac(2'd0, 16'h0100, 16'h0000));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (got !== e) $display("FAIL wcorner[%0d] got %h exp %h", i, got, e);
      else passes++;
      if (i == 3 || i == 4 || i == 6) begin
        checks++;
        if (pe_psum_out !== (i == 3 ? 16'h0100 : i == 4 ? 16'h0300 : 16'h0500))
          $display("FAIL wcorner_const[%0d] got %h", i, pe_psum_out);
        else passes++;
      end
    end
  endtask
  task automatic test_async_reset();
    stim_t q[$];
    drive(st(1, 0, 2'd0, 1, 16'h0700, 16'h0123, 1, 16'h0900, 1));
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (got !== '0) $display("FAIL async_reset got %h exp 0", got);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (got !== '0) $display("FAIL reset_hold got %h exp 0", got);
    else passes++;
    rst = 1'b1;
    q.push_back(swp());
    q.push_back(mac(2'd0, 16'h0100, 16'h0005));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (got !== e) $display("FAIL post_reset[%0d] got %h exp %h", i, got, e);
      else passes++;
    end
  endtask
  task automatic test_random();
    stim_t s;
    for (int i = 0; i < 150; i++) begin
      s = st($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, 2'($urandom), 1'($urandom),
             ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 1023)) : W'($urandom), W'($urandom),
             $urandom_range(0, 3) == 0, W'($urandom), $urandom_range(0, 3) == 0);
      drive(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (got !== e) $display("FAIL random[%0d] got %h exp %h", i, got, e);
      else passes++;
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_relu();
    test_stall_bypass();
    test_weight_corner();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
